// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Imported by the interface, the storage sub-module and the top.
package fetch_queue_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } fq_state_t;

    // addi x0, x0, 0: a harmless bubble for downstream latching
    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory bus: single outstanding request, active-low ack.
// Any cycle with req=1 and ack_n=0 transfers the word at addr.
interface fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_ack_n;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_data,
        input  imem_ack_n
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_data,
        output imem_ack_n
    );
endinterface

// File: rtl/fetch_fifo_mem.sv
// DEPTH x {pc, ir} storage: synchronous write, asynchronous head read.
// Pointer and occupancy bookkeeping live in the parent.
module fetch_fifo_mem
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  fetch_entry_t             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output fetch_entry_t             rdata
);

    fetch_entry_t mem [DEPTH];

    // NOTE: storage is not reset; the parent's count qualifies every read,
    // so stale contents are never observed and the array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer: runs its own fetch PC, absorbs memory wait
// states into a small {pc, ir} FIFO, and flushes on pipeline redirects.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    fetch_queue_if.master          imem,
    input  logic                   deq,
    output logic                   out_valid,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_pc4,
    output logic [31:0]            out_ir,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fq_state_t     state;
    logic          req_q;
    logic [31:0]   fetch_pc;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    fetch_entry_t  head;
    logic          push;
    logic          pop;

    // Redirect discards any ack or dequeue arriving in the same cycle.
    assign push = req_q && !imem.imem_ack_n && !redirect;
    assign pop  = deq && (count_q != '0) && !redirect;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= BOOT;
            req_q    <= 1'b0;
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
        end else if (redirect) begin
            state    <= RUN;
            req_q    <= 1'b1;
            fetch_pc <= redirect_pc & ~32'h0000_0003;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end

            // imem_req is a flop that tracks the next state, so deq never
            // reaches it combinationally.
            case (state)
                BOOT: begin
                    state <= RUN;
                    req_q <= 1'b1;
                end
                RUN: begin
                    if (push && !pop && count_q == CW'(DEPTH - 1)) begin
                        state <= FULL;
                        req_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state <= RUN;
                        req_q <= 1'b1;
                    end
                end
                default: begin
                    state <= BOOT;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ('{pc: fetch_pc, ir: imem.imem_data}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = fetch_pc;

    assign count     = count_q;
    assign out_valid = (count_q != '0);
    assign out_pc    = out_valid ? head.pc : 32'h0000_0000;
    assign out_ir    = out_valid ? head.ir : NOP_INSN;
    assign out_pc4   = out_pc + 32'd4;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, RESET_PC=0).
// Memory returns addr ^ 32'hDEAD_0000 so every word is traceable to its PC.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic [31:0] out_ir;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_queue_if bus ();

    assign bus.imem_data = bus.imem_addr ^ 32'hDEAD_0000;

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (bus),
        .deq         (deq),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_pc4     (out_pc4),
        .out_ir      (out_ir),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag, input logic [31:0] exp_count,
                           input logic exp_req, input logic [31:0] exp_addr);
        check({tag, ".count"}, 32'(count), exp_count);
        check({tag, ".req"}, 32'(bus.imem_req), 32'(exp_req));
        check({tag, ".addr"}, bus.imem_addr, exp_addr);
    endtask

    task automatic check_head(input string tag, input logic [31:0] exp_pc);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".pc"}, out_pc, exp_pc);
        check({tag, ".pc4"}, out_pc4, exp_pc + 32'd4);
        check({tag, ".ir"}, out_ir, exp_pc ^ 32'hDEAD_0000);
    endtask

    task automatic check_empty(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'd0);
        check({tag, ".pc"}, out_pc, 32'h0000_0000);
        check({tag, ".pc4"}, out_pc4, 32'h0000_0004);
        check({tag, ".ir"}, out_ir, 32'h0000_0013);
    endtask

    initial begin
        reset          = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        deq            = 1'b0;
        bus.imem_ack_n = 1'b0;

        // Reset and the BOOT cycle: no request yet
        tick();
        tick();
        check_q("reset", 0, 1'b0, 32'h0);
        check_empty("reset");
        reset = 1'b0;
        tick();
        check_q("boot_exit", 0, 1'b1, 32'h0);
        check_empty("boot_exit");

        // Free-running ack: fill 0x0, 0x4, then wait states at 0x8
        tick();
        check_q("push0", 1, 1'b1, 32'h4);
        check_head("push0", 32'h0);
        tick();
        check_q("push4", 2, 1'b1, 32'h8);
        bus.imem_ack_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_q("wait", 2, 1'b1, 32'h8);
        end
        bus.imem_ack_n = 1'b0;
        tick();
        check_q("push8", 3, 1'b1, 32'hC);
        tick();
        check_q("full", 4, 1'b0, 32'h10);
        check_head("full", 32'h0);

        // Full with deq: one pop, no push, back to RUN
        deq = 1'b1;
        tick();
        deq = 1'b0;
        check_q("full_deq", 3, 1'b1, 32'h10);
        check_head("full_deq", 32'h4);

        // Redirect at count=3 with a same-cycle ack (word at 0x10 dropped)
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        check_q("redir", 0, 1'b1, 32'h100);
        check_empty("redir");
        tick();
        check_q("redir_first", 1, 1'b1, 32'h104);
        check_head("redir_first", 32'h100);

        // Steady stream from 0: deq on empty is ignored, then count stays 1
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        deq         = 1'b1;
        tick();
        redirect = 1'b0;
        check_q("redir0", 0, 1'b1, 32'h0);
        tick();
        check_q("stream0", 1, 1'b1, 32'h4);
        check_head("stream0", 32'h0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_q("stream", 1, 1'b1, 32'(4 * i + 4));
            check_head("stream", 32'(4 * i));
        end

        // Address wrap past 0xFFFF_FFFC
        deq         = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        check_q("wrap_redir", 0, 1'b1, 32'hFFFF_FFF8);
        tick();
        check_q("wrap_a", 1, 1'b1, 32'hFFFF_FFFC);
        check_head("wrap_a", 32'hFFFF_FFF8);
        tick();
        check_q("wrap_b", 2, 1'b1, 32'h0);
        tick();
        check_q("wrap_c", 3, 1'b1, 32'h4);
        bus.imem_ack_n = 1'b1;
        deq            = 1'b1;
        tick();
        check_q("wrap_pop1", 2, 1'b1, 32'h4);
        check_head("wrap_pop1", 32'hFFFF_FFFC);
        check("wrap_pop1.pc4_wrap", out_pc4, 32'h0000_0000);
        tick();
        check_q("wrap_pop2", 1, 1'b1, 32'h4);
        check_head("wrap_pop2", 32'h0);

        // Reset mid-stream: drop everything, BOOT, restart at RESET_PC
        bus.imem_ack_n = 1'b0;
        deq            = 1'b0;
        reset          = 1'b1;
        tick();
        reset = 1'b0;
        check_q("mid_reset", 0, 1'b0, 32'h0);
        check_empty("mid_reset");
        tick();
        check_q("mid_boot", 0, 1'b1, 32'h0);
        tick();
        check_q("restart", 1, 1'b1, 32'h4);
        check_head("restart", 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction prefetch buffer between the instruction-memory bus and the IF-ID pipeline registers. It runs its own fetch PC, issues requests while it has free space, and absorbs ACKI_n-style wait states into a small FIFO of {pc, ir} entries. The IF-ID side pops entries at its own pace. A branch or jump redirect from the pipeline flushes the FIFO and restarts fetch at the target address.

Parameters:
DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
redirect  in  1  flush the FIFO and restart fetch at redirect_pc; pulse from the branch/jump resolution.
redirect_pc  in  32  redirect target; bits [1:0] are ignored and treated as 0.
imem_req  out  1  fetch request valid.
imem_addr  out  32  fetch address; equals fetch_pc.
imem_data  in  32  instruction word; valid in any cycle where imem_req=1 and imem_ack_n=0.
imem_ack_n  in  1  0 = data accepted/valid this cycle; 1 = wait.
deq  in  1  IF-ID consumes the head entry this cycle (pipeline not stalled).
out_valid  out  1  FIFO non-empty.
out_pc  out  32  PC of the head entry.
out_pc4  out  32  out_pc + 4, modulo 2^32.
out_ir  out  32  instruction of the head entry.
count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (reset=1 at an edge):
  - state=BOOT, fetch_pc=RESET_PC, read/write pointers=0, count=0.
  - imem_req=0, out_valid=0.
  - Reset overrides redirect, deq and ack. Reset mid-fetch drops the pending word.
- FSM states:
  - BOOT: one idle cycle after reset, imem_req=0. Goes to RUN unconditionally, or applies the redirect if redirect=1.
  - RUN: imem_req=1. Goes to FULL when a push without a pop makes count equal DEPTH.
  - FULL: imem_req=0. Goes to RUN when deq=1, with the entry popped that cycle.
- Push:
  - Occurs when imem_req=1 and imem_ack_n=0 at an edge, and redirect=0.
  - Writes {fetch_pc, imem_data} at the write pointer and advances the write pointer.
  - fetch_pc increments by 4; 32'hFFFF_FFFC wraps to 0.
  - Zero-cycle memory latency: the address and data are in the same cycle. Only one request is ever outstanding.
  - imem_ack_n=1 holds imem_addr stable and pushes nothing.
- Pop:
  - Occurs when deq=1 and count!=0; advances the read pointer.
  - deq while empty is ignored: no pointer motion, no error.
- Simultaneous push and pop (count between 1 and DEPTH-1): count is unchanged, both pointers advance.
- Push into an empty FIFO: the entry is visible on out_* in the next cycle, never the same cycle (no bypass).
- Full: no request is issued even when deq=1 in the same cycle. imem_req depends only on registered state, so there is no combinational path from deq to imem_req.
- Redirect takes priority over push and pop:
  - pointers=0, count=0, fetch_pc={redirect_pc[31:2],2'b00}, state=RUN.
  - An ack arriving in the redirect cycle is discarded.
  - Fetch from the target starts the next cycle.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. count is tracked separately so full and empty are unambiguous.
- Empty-FIFO outputs: out_valid=0, out_pc=0, out_pc4=4, out_ir=32'h0000_0013 (NOP), so downstream can latch a bubble safely.
- All outputs are registered-state driven except out_pc4, which is an adder on the head PC.

Decomposition:
- Shared package: FSM state encoding (BOOT=2'd0, RUN=2'd1, FULL=2'd2), the NOP constant 32'h0000_0013, and RESET_PC default.
- One sub-module, fetch_fifo_mem: DEPTH x 64-bit storage with synchronous write and asynchronous read of the head. Pointer and count logic stay in fetch_queue.

Test Plan:
- Reset then free-running ack (imem_ack_n=0, deq=0):
  - BOOT cycle has imem_req=0.
  - Then addresses 0x0, 0x4, 0x8, 0xC are pushed, count reaches 4, state=FULL, imem_req=0.
- Wait states: imem_ack_n=1 for 3 cycles at addr 0x8 → imem_addr holds 0x8, count is unchanged, the push occurs on the first ack=0 cycle.
- Steady stream with deq=1 and ack=0 every cycle:
  - count settles at 1.
  - out_pc sequence is 0x0, 0x4, 0x8, …, with out_pc4 = out_pc + 4 and out_ir matching the memory words.
- Redirect while count=3 and ack=0 in the same cycle, redirect_pc=0x0000_0103:
  - next cycle count=0, out_valid=0, out_ir=0x13, imem_addr=0x100.
  - the acked word is not stored.
- Full with deq=1: exactly one pop, no push that cycle; next cycle state=RUN, imem_req=1, count=3.
- Wrap and reset:
  - redirect_pc=0xFFFF_FFF8 → pushes from 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
  - reset asserted mid-stream → next cycle count=0, imem_req=0, fetch restarts at RESET_PC after BOOT.
